faxi_beat_gen: RTL and testbench
================================

# faxi_beat_gen

Per-beat address sequencer for an AXI4 slave. It accepts one AR/AW-style burst request through a valid/ready handshake and emits one address per data beat through a second valid/ready handshake, flagging the last beat. Beat-to-beat stepping uses the team's FIXED/INCR/WRAP next-address rules, which are embedded here. It sits between the slave's address-channel skid buffer and its memory/data-path stage.

## Interface
- AW, default 32, address width in bits.
- i_clk  input  1  single clock; all state updates on the rising edge.
- i_reset  input  1  reset, asynchronous and active-high.
- i_req_valid  input  1  burst request valid.
- o_req_ready  output  1  request accepted when high together with i_req_valid.
- i_req_addr  input  AW  start address; may be unaligned for INCR and FIXED.
- i_req_len  input  8  beats minus one (0–255).
- i_req_size  input  3  bytes per beat = 2^size.
- i_req_burst  input  2  00 FIXED, 01 INCR, 11 WRAP, 10 reserved.
- o_beat_valid  output  1  beat address valid.
- i_beat_ready  input  1  consumer takes the beat.
- o_beat_addr  output  AW  current beat address.
- o_beat_idx  output  8  beat number within the burst, 0-based.
- o_beat_last  output  1  high when o_beat_idx equals latched len.
- o_busy  output  1  high while in BURST.

## Operation
- Two states: IDLE and BURST.
  - IDLE: o_req_ready=1 and o_beat_valid=0. On i_req_valid, latch len, size, and burst; load o_beat_addr from i_req_addr, clear o_beat_idx, and enter BURST.
  - BURST: o_req_ready=0 and o_beat_valid=1. On a beat handshake (o_beat_valid & i_beat_ready):
    - If o_beat_last: go to IDLE.
    - Otherwise: o_beat_addr <= next(o_beat_addr) and o_beat_idx <= o_beat_idx+1.
- next(a) rules:
  - FIXED: next(a) = a.
  - INCR: next(a) = a + 2^size, with the low `size` bits then cleared. Sum is modulo 2^AW.
  - WRAP: mask = 2^(size+log2(len+1)) − 1. next(a) = (a & ~mask) | (incr_aligned & mask), where incr_aligned is the INCR result.
- Request sanitising, applied at latch time:
  - Burst 10 (reserved) is latched as FIXED.
  - WRAP with len not in {1, 3, 7, 15} is latched as INCR.
  - WRAP start addresses are used as given. The bench supplies only size-aligned WRAP starts.
- o_beat_last is combinational from the registered idx and latched len.
- All other beat outputs are registered.
- While o_beat_valid=1 and i_beat_ready=0, o_beat_addr, o_beat_idx, and o_beat_last hold stable.
- i_req_* inputs are ignored outside IDLE.

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - State=IDLE.
  - o_beat_valid=0, o_beat_addr=0, o_beat_idx=0, o_busy=0.
  - o_beat_last=1, because idx 0 equals reset len 0. It is qualified by o_beat_valid=0.
  - o_req_ready=0 while i_reset is high, then 1 from the first cycle after release.
- Request accepted at edge T: first beat is valid in cycle T+1. Request-to-first-beat latency is 1 cycle.
- Throughput is one beat per cycle with i_beat_ready held high. A burst of len+1 beats occupies len+1 cycles in BURST.
- Last-beat handshake at edge T: o_req_ready=1 in cycle T+1. There is no same-cycle overlap, so back-to-back bursts cost one idle cycle.
- Reset asserted mid-burst: outputs return to reset values immediately. The burst is abandoned and nothing resumes.

## Test plan
- INCR, addr 0x1003, size 2, len 3, i_beat_ready=1 -> beats 0x1003, 0x1004, 0x1008, 0x100C; idx 0–3; last only on the 4th beat; o_req_ready back high the next cycle.
- WRAP, addr 0x18, size 3, len 3 -> 0x18, 0x00, 0x08, 0x10. WRAP, addr 0x2C, size 2, len 1 -> 0x2C, 0x28.
- FIXED, addr 0x40, size 2, len 2 -> 0x40 three times. Reserved burst 10 gives the same result. WRAP with len 2 at addr 0x10, size 2 -> 0x10, 0x14, 0x18 (INCR).
- Backpressure: INCR addr 0x0, size 0, len 4; i_beat_ready low for 3 cycles at idx 2 -> addr 0x2 and idx 2 held for 3 cycles, then 0x3 and 0x4; exactly 5 handshakes.
- Address overflow: INCR addr 0xFFFFFFFC (AW=32), size 2, len 1 -> 0xFFFFFFFC, then 0x00000000 with last=1.
- Reset mid-burst: assert i_reset at idx 1 of a len-7 burst -> o_beat_valid=0 and o_beat_addr=0 without waiting for a clock edge. After release, o_req_ready=1, and a new request INCR 0x100, size 2, len 0 gives a single beat 0x100 with last=1.

Source files
------------

// File: rtl/faxi_beat_gen.sv
// AXI4 burst-to-beat address sequencer: takes one AR/AW-style request
// and walks FIXED/INCR/WRAP beat addresses out over a valid/ready port.
module faxi_beat_gen #(
  parameter int AW = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic [AW-1:0] i_req_addr,
  input  logic [7:0]    i_req_len,
  input  logic [2:0]    i_req_size,
  input  logic [1:0]    i_req_burst,
  output logic          o_beat_valid,
  input  logic          i_beat_ready,
  output logic [AW-1:0] o_beat_addr,
  output logic [7:0]    o_beat_idx,
  output logic          o_beat_last,
  output logic          o_busy
);

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_e;

  localparam logic [1:0] B_FIXED = 2'b00;
  localparam logic [1:0] B_INCR  = 2'b01;
  localparam logic [1:0] B_WRAP  = 2'b11;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    len_q, len_d;
  logic [2:0]    size_q, size_d;
  logic [1:0]    burst_q, burst_d;
  logic          valid_q, valid_d;

  logic [AW-1:0] step;
  logic [AW-1:0] incr_addr;
  logic [AW-1:0] wrap_mask;
  logic [AW-1:0] next_addr;
  logic [3:0]    wrap_lg;
  logic          req_wrap_ok;
  logic [1:0]    req_burst_s;
  logic          beat_hs;
  logic          last;

  assign step      = AW'(1) << size_q;
  assign incr_addr = (addr_q + step) & ~(step - AW'(1));
  assign last      = (idx_q == len_q);
  assign beat_hs   = valid_q & i_beat_ready;

  // Wrap boundary spans (len+1) beats; only legal wrap lengths latch as WRAP.
  always_comb begin
    wrap_lg = 4'd0;
    case (len_q)
      8'd1:    wrap_lg = 4'd1;
      8'd3:    wrap_lg = 4'd2;
      8'd7:    wrap_lg = 4'd3;
      8'd15:   wrap_lg = 4'd4;
      default: wrap_lg = 4'd0;
    endcase
  end

  assign wrap_mask = (AW'(1) << (4'(size_q) + wrap_lg)) - AW'(1);

  always_comb begin
    next_addr = incr_addr;
    case (burst_q)
      B_FIXED: next_addr = addr_q;
      B_WRAP:  next_addr = (addr_q & ~wrap_mask)
                         | (incr_addr & wrap_mask);
      default: next_addr = incr_addr;
    endcase
  end

  assign req_wrap_ok = (i_req_len == 8'd1) || (i_req_len == 8'd3)
                    || (i_req_len == 8'd7) || (i_req_len == 8'd15);

  always_comb begin
    req_burst_s = i_req_burst;
    if (i_req_burst == 2'b10)
      req_burst_s = B_FIXED;
    else if (i_req_burst == B_WRAP && !req_wrap_ok)
      req_burst_s = B_INCR;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    valid_d = valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          len_d   = i_req_len;
          size_d  = i_req_size;
          burst_d = req_burst_s;
          addr_d  = i_req_addr;
          idx_d   = 8'd0;
          valid_d = 1'b1;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (beat_hs) begin
          if (last) begin
            valid_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            addr_d = next_addr;
            idx_d  = idx_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= B_FIXED;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      valid_q <= valid_d;
    end
  end

  // Ready is held low for as long as reset is asserted.
  assign o_req_ready  = (state_q == S_IDLE) && !i_reset;
  assign o_beat_valid = valid_q;
  assign o_beat_addr  = addr_q;
  assign o_beat_idx   = idx_q;
  assign o_beat_last  = last;
  assign o_busy       = (state_q == S_BURST);

endmodule

// File: tb/tb_faxi_beat_gen.sv
// Directed bench for faxi_beat_gen: a per-burst beat-list model checked
// every cycle, plus literal address sequences for each directed burst.
module tb_faxi_beat_gen;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [31:0] i_req_addr = '0;
  logic [7:0]  i_req_len = '0;
  logic [2:0]  i_req_size = '0;
  logic [1:0]  i_req_burst = '0;
  logic        o_beat_valid;
  logic        i_beat_ready = 1'b0;
  logic [31:0] o_beat_addr;
  logic [7:0]  o_beat_idx;
  logic        o_beat_last;
  logic        o_busy;

  faxi_beat_gen #(.AW(32)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_addr   (i_req_addr),
    .i_req_len    (i_req_len),
    .i_req_size   (i_req_size),
    .i_req_burst  (i_req_burst),
    .o_beat_valid (o_beat_valid),
    .i_beat_ready (i_beat_ready),
    .o_beat_addr  (o_beat_addr),
    .o_beat_idx   (o_beat_idx),
    .o_beat_last  (o_beat_last),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  idx;
    logic        last;
  } beat_t;

  beat_t       mq[$];
  logic [31:0] log_q[$];
  logic [31:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;
  int idx2_cycles = 0;

  function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endfunction

  // Whole-burst address list from the burst rules: aligned base plus
  // beat offset, wrapped modulo the total burst span for WRAP.
  function automatic void model_push(logic [31:0] a, logic [7:0] l,
                                     logic [2:0] s, logic [1:0] b);
    longint unsigned la = {32'b0, a};
    longint unsigned bytes = 64'd1 << s;
    longint unsigned total = bytes * (longint'(l) + 1);
    longint unsigned base;
    longint unsigned v;
    int eb = int'(b);
    beat_t bt;
    if (b == 2'b10) eb = 0;
    if (b == 2'b11 && !(l inside {8'd1, 8'd3, 8'd7, 8'd15})) eb = 1;
    for (int i = 0; i <= int'(l); i++) begin
      case (eb)
        0: v = la;
        3: begin
          base = la & ~(total - 1);
          v = base + ((la - base + longint'(i) * bytes) % total);
        end
        default: v = (i == 0) ? la
                   : (la & ~(bytes - 1)) + longint'(i) * bytes;
      endcase
      bt.addr = v[31:0];
      bt.idx  = i[7:0];
      bt.last = (i == int'(l));
      mq.push_back(bt);
    end
  endfunction

  always @(negedge i_clk) begin
    if (i_reset) begin
      mq.delete();
    end else begin
      chk("beat_valid", {63'b0, o_beat_valid}, {63'b0, mq.size() != 0});
      chk("req_ready", {63'b0, o_req_ready}, {63'b0, mq.size() == 0});
      chk("busy", {63'b0, o_busy}, {63'b0, mq.size() != 0});
      if (o_beat_valid && o_beat_idx == 8'd2) idx2_cycles++;
      if (mq.size() != 0 && o_beat_valid) begin
        chk("beat_addr", {32'b0, o_beat_addr}, {32'b0, mq[0].addr});
        chk("beat_idx", {56'b0, o_beat_idx}, {56'b0, mq[0].idx});
        chk("beat_last", {63'b0, o_beat_last}, {63'b0, mq[0].last});
        if (i_beat_ready) begin
          log_q.push_back(o_beat_addr);
          hs_cnt++;
          void'(mq.pop_front());
        end
      end else if (o_req_ready && i_req_valid) begin
        model_push(i_req_addr, i_req_len, i_req_size, i_req_burst);
      end
    end
  end

  // Called at posedge+1 while idle; returns at posedge+1.
  task automatic run_burst(input logic [31:0] a, input logic [7:0] l,
                           input logic [2:0] s, input logic [1:0] b,
                           input int stall_at, input int stall_n,
                           input int abort_at);
    int stalls = 0;
    int cyc = 0;
    log_q.delete();
    hs_cnt = 0;
    idx2_cycles = 0;
    i_req_valid = 1'b1;
    i_req_addr  = a;
    i_req_len   = l;
    i_req_size  = s;
    i_req_burst = b;
    i_beat_ready = 1'b1;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    i_req_addr  = 32'hDEAD_BEEF;
    i_req_len   = 8'hFF;
    forever begin
      if (abort_at >= 0 && o_beat_valid && int'(o_beat_idx) == abort_at)
        return;
      if (!o_beat_valid && o_req_ready) break;
      if (o_beat_valid && int'(o_beat_idx) == stall_at && stalls < stall_n) begin
        i_beat_ready = 1'b0;
        stalls++;
      end else begin
        i_beat_ready = 1'b1;
      end
      @(posedge i_clk); #1;
      cyc++;
      if (cyc > 600) begin
        checks++;
        failures++;
        $display("FAIL burst_timeout actual=%0d expected<=600", cyc);
        break;
      end
    end
  endtask

  task automatic chk_log(string n);
    chk({n, "_count"}, 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk(n, {32'b0, log_q[i]}, {32'b0, exp_q[i]});
  endtask

  task automatic chk_reset_vals(string n);
    chk({n, "_valid"}, {63'b0, o_beat_valid}, 64'd0);
    chk({n, "_addr"}, {32'b0, o_beat_addr}, 64'd0);
    chk({n, "_idx"}, {56'b0, o_beat_idx}, 64'd0);
    chk({n, "_last"}, {63'b0, o_beat_last}, 64'd1);
    chk({n, "_ready"}, {63'b0, o_req_ready}, 64'd0);
    chk({n, "_busy"}, {63'b0, o_busy}, 64'd0);
  endtask

  initial begin
    @(posedge i_clk); #1;
    chk_reset_vals("reset");
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    #1;
    chk("ready_after_reset", {63'b0, o_req_ready}, 64'd1);
    @(posedge i_clk); #1;

    run_burst(32'h1003, 8'd3, 3'd2, 2'b01, -1, 0, -1);
    exp_q = '{32'h1003, 32'h1004, 32'h1008, 32'h100C};
    chk_log("incr_unaligned");
    chk("incr_ready_next", {63'b0, o_req_ready}, 64'd1);

    run_burst(32'h18, 8'd3, 3'd3, 2'b11, -1, 0, -1);
    exp_q = '{32'h18, 32'h00, 32'h08, 32'h10};
    chk_log("wrap_len3");

    run_burst(32'h2C, 8'd1, 3'd2, 2'b11, -1, 0, -1);
    exp_q = '{32'h2C, 32'h28};
    chk_log("wrap_len1");

    run_burst(32'h40, 8'd2, 3'd2, 2'b00, -1, 0, -1);
    exp_q = '{32'h40, 32'h40, 32'h40};
    chk_log("fixed");

    run_burst(32'h40, 8'd2, 3'd2, 2'b10, -1, 0, -1);
    exp_q = '{32'h40, 32'h40, 32'h40};
    chk_log("reserved_as_fixed");

    run_burst(32'h10, 8'd2, 3'd2, 2'b11, -1, 0, -1);
    exp_q = '{32'h10, 32'h14, 32'h18};
    chk_log("wrap_bad_len");

    run_burst(32'h0, 8'd4, 3'd0, 2'b01, 2, 3, -1);
    exp_q = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4};
    chk_log("backpressure");
    chk("bp_handshakes", 64'(hs_cnt), 64'd5);
    chk("bp_idx2_cycles", 64'(idx2_cycles), 64'd4);

    run_burst(32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01, -1, 0, -1);
    exp_q = '{32'hFFFF_FFFC, 32'h0000_0000};
    chk_log("overflow");

    run_burst(32'h200, 8'd7, 3'd2, 2'b01, -1, 0, 1);
    chk("abort_idx", {56'b0, o_beat_idx}, 64'd1);
    #1;
    i_reset = 1'b1;
    #1;
    chk_reset_vals("mid_reset");
    @(posedge i_clk);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    #1;
    chk("ready_after_mid_reset", {63'b0, o_req_ready}, 64'd1);
    chk("valid_after_mid_reset", {63'b0, o_beat_valid}, 64'd0);
    @(posedge i_clk); #1;

    run_burst(32'h100, 8'd0, 3'd2, 2'b01, -1, 0, -1);
    exp_q = '{32'h100};
    chk_log("single_beat");

    repeat (2) @(posedge i_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
